// File: rtl/seven_seg_scan_decoder_if.sv
// Display-side pins and reassembled-value outputs of the seven-segment scan decoder.
// master drives the display lines and observes the result; slave is the decoder.
interface seven_seg_scan_decoder_if #(
    parameter int OUTPUT_WIDTH = 15
);
    logic [3:0]              anodes;
    logic [7:0]              cathodes;
    logic [OUTPUT_WIDTH-1:0] o_number;
    logic [3:0]              o_decimal_points;
    logic                    o_digit_err;
    logic                    o_valid;

    modport master (
        output anodes, cathodes,
        input  o_number, o_decimal_points, o_digit_err, o_valid
    );

    modport slave (
        input  anodes, cathodes,
        output o_number, o_decimal_points, o_digit_err, o_valid
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers a 4-digit value from a multiplexed active-low 7-seg display; o_valid pulses
// 5 cycles after the frame's last capture strobe. No backpressure: results are held until the next pulse.
module seven_seg_scan_decoder #(
    parameter int OUTPUT_WIDTH  = 15,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    seven_seg_scan_decoder_if.slave bus
);
    typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STROBE_AT  = 8'(STABLE_CYCLES - 2);

    logic [11:0] sync_d [SYNC_STAGES];
    logic [11:0] sync_q [SYNC_STAGES];
    logic [11:0] sample, prev_q;
    logic [7:0]  cnt_d, cnt_q;
    logic        stable, strobe;

    logic        an_hot, dec_err;
    logic [1:0]  an_idx;
    logic [3:0]  an_bit, dec_digit;

    state_t      state_q;
    logic [3:0]  mask_q, dp_q, err_q;
    logic [3:0]  digit_q [4];
    logic [1:0]  idx_q;
    logic [13:0] acc_q, acc_x10, acc_next;
    logic [17:0] acc_wide;

    logic [OUTPUT_WIDTH-1:0] number_q;
    logic [3:0]              dp_out_q;
    logic                    err_out_q, valid_q;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode = {1'b0, 4'd0};
            7'b0110000: decode = {1'b0, 4'd1};
            7'b1101101: decode = {1'b0, 4'd2};
            7'b1111001: decode = {1'b0, 4'd3};
            7'b0110011: decode = {1'b0, 4'd4};
            7'b1011011: decode = {1'b0, 4'd5};
            7'b1011111: decode = {1'b0, 4'd6};
            7'b1110000: decode = {1'b0, 4'd7};
            7'b1111111: decode = {1'b0, 4'd8};
            7'b1111011: decode = {1'b0, 4'd9};
            default:    decode = {1'b1, 4'd0};
        endcase
    endfunction

    always_comb begin
        sync_d[0] = {bus.anodes, bus.cathodes};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

    // Strobe on the cycle the count steps to STABLE_CYCLES-1: exactly once per stable period.
    always_comb begin
        stable = (sample == prev_q);
        strobe = stable && (cnt_q == STROBE_AT);
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            prev_q <= '1;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q <= sample;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        an_hot = 1'b1;
        an_idx = 2'd0;
        case (sample[11:8])
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_hot = 1'b0;
        endcase
        an_bit               = 4'b0001 << an_idx;
        {dec_err, dec_digit} = decode(~sample[7:1]);
    end

    // acc*10 as shift-add in a wider word; truncation is lossless for BCD inputs.
    assign acc_wide = {4'b0, acc_q};
    assign acc_x10  = 14'((acc_wide << 3) + (acc_wide << 1));
    assign acc_next = acc_x10 + {10'b0, digit_q[idx_q]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= COLLECT;
            mask_q    <= '0;
            dp_q      <= '0;
            err_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= '0;
            end
            number_q  <= '0;
            dp_out_q  <= '0;
            err_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (strobe && an_hot) begin
                        digit_q[an_idx] <= dec_digit;
                        dp_q[an_idx]    <= ~sample[0];
                        err_q[an_idx]   <= dec_err;
                        if ((mask_q | an_bit) == 4'b1111) begin
                            state_q <= CONVERT;
                            mask_q  <= '0;
                            acc_q   <= '0;
                            idx_q   <= 2'd3;
                        end else begin
                            mask_q <= mask_q | an_bit;
                        end
                    end
                end
                CONVERT: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q - 2'd1;
                    if (idx_q == 2'd0) begin
                        state_q   <= DONE;
                        number_q  <= OUTPUT_WIDTH'(acc_next);
                        dp_out_q  <= dp_q;
                        err_out_q <= |err_q;
                        valid_q   <= 1'b1;
                    end
                end
                DONE:    state_q <= COLLECT;
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.o_number         = number_q;
    assign bus.o_decimal_points = dp_out_q;
    assign bus.o_digit_err      = err_out_q;
    assign bus.o_valid          = valid_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: each scanned frame pushes its expected result; the monitor pops on o_valid.
module tb_seven_seg_scan_decoder;
    localparam int OW = 15;
    localparam int SC = 4;

    typedef struct {
        int         num;
        logic [3:0] dp;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_decoder_if #(.OUTPUT_WIDTH(OW)) bus ();

    seven_seg_scan_decoder #(
        .OUTPUT_WIDTH (OW),
        .STABLE_CYCLES(SC),
        .SYNC_STAGES  (2)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   an3_cyc = 0;
    bit   lat_armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'b1111110;
            1: seg_of = 7'b0110000;
            2: seg_of = 7'b1101101;
            3: seg_of = 7'b1111001;
            4: seg_of = 7'b0110011;
            5: seg_of = 7'b1011011;
            6: seg_of = 7'b1011111;
            7: seg_of = 7'b1110000;
            8: seg_of = 7'b1111111;
            default: seg_of = 7'b1111011;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int k, input logic [6:0] seg, input logic dp, input int hold);
        bus.anodes    = 4'b1111;
        bus.anodes[k] = 1'b0;
        bus.cathodes  = ~{seg, dp};
        if (k == 3) an3_cyc = cyc;
        tick(hold);
    endtask

    task automatic idle(input int n);
        bus.anodes   = 4'b1111;
        bus.cathodes = 8'hFF;
        tick(n);
    endtask

    task automatic frame(input int d0, input int d1, input int d2, input int d3,
                         input logic [3:0] dp, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.num = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
            e.dp  = dp;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        show(0, seg_of(d0), dp[0], 8);
        show(1, seg_of(d1), dp[1], 8);
        show(2, seg_of(d2), dp[2], 8);
        show(3, seg_of(d3), dp[3], 8);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_vld", {31'b0, bus.o_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("number", {17'b0, bus.o_number}, mon_e.num);
                chk("dp",     {28'b0, bus.o_decimal_points}, {28'b0, mon_e.dp});
                chk("err",    {31'b0, bus.o_digit_err}, {31'b0, mon_e.err});
                if (lat_armed) begin
                    chk("latency", cyc - an3_cyc, 32'd10);
                    lat_armed = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.anodes   = 4'b1111;
        bus.cathodes = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_number", {17'b0, bus.o_number}, 32'd0);
        chk("rst_dp",     {28'b0, bus.o_decimal_points}, 32'd0);
        chk("rst_err",    {31'b0, bus.o_digit_err}, 32'd0);
        chk("rst_valid",  {31'b0, bus.o_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // basic frame with latency measurement from the AN3 pin change
        lat_armed = 1'b1;
        frame(4, 3, 2, 1, 4'b0000, 1'b1);
        idle(20);

        frame(9, 9, 9, 9, 4'b0010, 1'b1);
        idle(20);

        // unrecognised pattern on AN2
        e.num = 0; e.dp = 4'b0000; e.err = 1'b1;
        exp_q.push_back(e);
        show(0, seg_of(0), 1'b0, 8);
        show(1, seg_of(0), 1'b0, 8);
        show(2, 7'b0000001, 1'b0, 8);
        show(3, seg_of(0), 1'b0, 8);
        idle(20);

        // continuous scan; AN3 changes while its frame is converting and must be ignored
        repeat (3) frame(5, 6, 7, 8, 4'b0000, 1'b1);
        e.num = 8765; e.dp = 4'b0000; e.err = 1'b0;
        exp_q.push_back(e);
        show(0, seg_of(5), 1'b0, 8);
        show(1, seg_of(6), 1'b0, 8);
        show(2, seg_of(7), 1'b0, 8);
        show(3, seg_of(8), 1'b0, 5);
        show(3, seg_of(1), 1'b0, 8);
        repeat (2) frame(0, 0, 0, 1, 4'b0000, 1'b1);
        idle(20);

        // AN0 too short to capture, then an illegal two-cold anode pattern: no result
        repeat (2) begin
            show(0, seg_of(7), 1'b0, SC - 2);
            show(1, seg_of(3), 1'b0, 8);
            show(2, seg_of(3), 1'b0, 8);
            show(3, seg_of(3), 1'b0, 8);
        end
        idle(20);
        bus.anodes   = 4'b0011;
        bus.cathodes = ~{seg_of(5), 1'b0};
        tick(32);
        idle(20);

        // AN0 completes the pending mask; reset lands mid-conversion
        chk("pre_rst_number", {17'b0, bus.o_number}, 32'd1000);
        show(0, seg_of(2), 1'b0, 7);
        rst_n        = 1'b0;
        bus.anodes   = 4'b1111;
        bus.cathodes = 8'hFF;
        #1;
        chk("midrst_valid",  {31'b0, bus.o_valid}, 32'd0);
        chk("midrst_number", {17'b0, bus.o_number}, 32'd0);
        chk("midrst_dp",     {28'b0, bus.o_decimal_points}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        idle(25);
        frame(2, 4, 6, 8, 4'b1000, 1'b1);
        idle(20);

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
